// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: register offsets, CTRL layout,
// MODE encodings and the STATUS bit index.
package led_sequencer_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_DATA   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_DUTY   = 3'd4;

    localparam int unsigned STATUS_WRAP_BIT = 0;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_SHL    = 2'b10,
        MODE_SHR    = 2'b11
    } mode_e;

    // CTRL register: IE in bit 2, MODE in bits 1:0
    typedef struct packed {
        logic  ie;
        mode_e mode;
    } ctrl_t;

endpackage

// File: rtl/led_seq_pwm.sv
// Free-running PWM counter and duty compare for the LED output gate.
// Only instantiated when LED_SEQ_PWM_EN is defined.
module led_seq_pwm #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             led_en_o
);

    logic [PWM_W-1:0] p_q;

    // Free-running PWM phase counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_q <= '0;
        end else begin
            p_q <= p_q + PWM_W'(1);
        end
    end

    // All-ones duty means fully on; otherwise on while phase is below duty
    assign led_en_o = (duty_i == '1) | (p_q < duty_i);

endmodule

// File: rtl/led_sequencer.sv
// Bus-mapped LED sequencer: forwards CPU writes to the LED register in MANUAL
// mode and runs a prescaled BLINK/SHL/SHR pattern engine otherwise.
// Optional PWM brightness gate: define LED_SEQ_PWM_EN.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned PWM_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] led_din,
    output logic        led_we,
    output logic        led_en,
    output logic        irq
);

    ctrl_t               ctrl_q,    ctrl_d;
    logic [WIDTH-1:0]    data_q,    data_d;
    logic [PERIOD_W-1:0] period_q,  period_d;
    logic [PERIOD_W-1:0] cnt_q,     cnt_d;
    logic [5:0]          step_q,    step_d;
    logic                wrap_q,    wrap_d;
    logic                led_we_q,  led_we_d;
    logic [31:0]         led_din_q, led_din_d;

    logic wr_ctrl, wr_data, wr_period, wr_status;
    logic engine_on, cnt_at_end, tick;
    logic [5:0] step_lim;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_data   = we && (addr == ADDR_DATA);
    assign wr_period = we && (addr == ADDR_PERIOD);
    assign wr_status = we && (addr == ADDR_STATUS);

    assign engine_on  = (ctrl_q.mode != MODE_MANUAL) && (period_q != '0);
    assign cnt_at_end = (cnt_q == period_q - PERIOD_W'(1));
    // CPU writes to DATA or CTRL take priority over an engine tick in the same cycle
    assign tick       = engine_on && cnt_at_end && !wr_data && !wr_ctrl;
    assign step_lim   = (ctrl_q.mode == MODE_BLINK) ? 6'd2 : 6'(WIDTH);

    function automatic logic [WIDTH-1:0] next_pattern(mode_e m, logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            MODE_BLINK: r = ~d;
            MODE_SHL:   for (int unsigned i = 0; i < WIDTH; i++) r[(i + 1) % WIDTH] = d[i];
            MODE_SHR:   for (int unsigned i = 0; i < WIDTH; i++) r[i] = d[(i + 1) % WIDTH];
            default:    r = d;
        endcase
        return r;
    endfunction

`ifdef LED_SEQ_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             wr_duty;

    assign wr_duty = we && (addr == ADDR_DUTY);

    led_seq_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk_i    (clk),
        .reset_i  (reset),
        .duty_i   (duty_q),
        .led_en_o (led_en)
    );
`else
    assign led_en = 1'b1;
`endif

    // Next-state: prescaler, step/wrap tracking, CPU-vs-engine arbitration
    always_comb begin
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        period_d  = period_q;
        step_d    = step_q;
        wrap_d    = wrap_q;
        led_we_d  = 1'b0;
        led_din_d = led_din_q;
`ifdef LED_SEQ_PWM_EN
        duty_d    = duty_q;
        if (wr_duty) duty_d = wdata[PWM_W-1:0];
`endif

        if (!engine_on || cnt_at_end) cnt_d = '0;
        else                          cnt_d = cnt_q + PERIOD_W'(1);

        // Clear first so a wrap in the same cycle wins
        if (wr_status) wrap_d = 1'b0;

        if (tick) begin
            data_d   = next_pattern(ctrl_q.mode, data_q);
            led_we_d = 1'b1;
            if (step_q + 6'd1 == step_lim) begin
                step_d = '0;
                wrap_d = 1'b1;
            end else begin
                step_d = step_q + 6'd1;
            end
        end

        if (wr_data) begin
            data_d   = wdata[WIDTH-1:0];
            led_we_d = 1'b1;
            cnt_d    = '0;
        end

        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(wdata[2:0]);
            cnt_d  = '0;
            step_d = '0;
        end

        // Compare against the next count so a shorter period never strands cnt past it
        if (wr_period) begin
            period_d = wdata[PERIOD_W-1:0];
            if (period_d <= cnt_d) cnt_d = '0;
        end

        if (led_we_d) begin
            led_din_d              = '0;
            led_din_d[WIDTH-1:0]   = data_d;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= ctrl_t'('0);
            data_q    <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            step_q    <= '0;
            wrap_q    <= 1'b0;
            led_we_q  <= 1'b0;
            led_din_q <= '0;
`ifdef LED_SEQ_PWM_EN
            duty_q    <= '1;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            led_we_q  <= led_we_d;
            led_din_q <= led_din_d;
`ifdef LED_SEQ_PWM_EN
            duty_q    <= duty_d;
`endif
        end
    end

    // Combinational register readback, zero-extended
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata[2:0]             = ctrl_q;
            ADDR_DATA:   rdata[WIDTH-1:0]       = data_q;
            ADDR_PERIOD: rdata[PERIOD_W-1:0]    = period_q;
            ADDR_STATUS: rdata[STATUS_WRAP_BIT] = wrap_q;
`ifdef LED_SEQ_PWM_EN
            ADDR_DUTY:   rdata[PWM_W-1:0]       = duty_q;
`endif
            default:     rdata = '0;
        endcase
    end

    assign led_we  = led_we_q;
    assign led_din = led_din_q;
    assign irq     = wrap_q & ctrl_q.ie;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: expected LED write pulses (cycle and
// value) are queued as stimulus is applied and matched as the DUT emits them.
module tb_led_sequencer;
    import led_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, led_din;
    logic        led_we, led_en, irq;

`ifdef LED_SEQ_PWM_EN
    localparam logic [31:0] DUTY_RST = 32'h0000_00FF;
`else
    localparam logic [31:0] DUTY_RST = 32'h0;
`endif

    led_sequencer #(.WIDTH(32), .PERIOD_W(32), .PWM_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .led_din (led_din),
        .led_we  (led_we),
        .led_en  (led_en),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] din;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: every LED write pulse must match the oldest expectation
    always @(negedge clk) begin
        if (led_we === 1'b1) begin
            exp_t e;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL led_we_pulse: unexpected pulse at cycle %0d din=%h, required none", cyc, led_din);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || led_din !== e.din) begin
                    n_fail++;
                    $display("FAIL led_we_pulse: got cycle %0d din=%h, required cycle %0d din=%h",
                             cyc, led_din, e.cyc, e.din);
                end
            end
        end
    end

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x);
        return {x[0], x[31:1]};
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int unsigned e);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        e  = cyc;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int unsigned budget, input string name);
        int unsigned k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d expected pulses never seen, next due cycle %0d din=%h",
                     name, sb.size(), sb[0].cyc, sb[0].din);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (led_we !== 1'b0)   begin n_fail++; $display("FAIL reset_led_we: got %b, required 0", led_we); end
        n_tests++; if (led_din !== 32'h0) begin n_fail++; $display("FAIL reset_led_din: got %h, required 0", led_din); end
        n_tests++; if (led_en !== 1'b1)   begin n_fail++; $display("FAIL reset_led_en: got %b, required 1", led_en); end
        n_tests++; if (irq !== 1'b0)      begin n_fail++; $display("FAIL reset_irq: got %b, required 0", irq); end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), r);
            n_tests++;
            if (r !== ((a == 4) ? DUTY_RST : 32'h0)) begin
                n_fail++;
                $display("FAIL reset_rdata[%0d]: got %h, required %h", a, r, (a == 4) ? DUTY_RST : 32'h0);
            end
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_manual();
        int unsigned e;
        logic [31:0] r;
        bus_write(ADDR_DATA, 32'h0000_00A5, e);
        sb.push_back('{e, 32'h0000_00A5});
        idle(10);
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL manual_pulse: %0d pulses pending, required 0", sb.size()); sb.delete(); end
        bus_read(ADDR_DATA, r);
        n_tests++; if (r !== 32'hA5) begin n_fail++; $display("FAIL manual_readback: got %h, required 000000a5", r); end
    endtask

    task automatic test_shl();
        int unsigned e, c;
        logic [31:0] m, r;
        bus_write(ADDR_PERIOD, 32'd4, e);
        bus_write(ADDR_DATA, 32'h1, e);
        sb.push_back('{e, 32'h1});
        bus_write(ADDR_CTRL, 32'h2, c);
        m = 32'h1;
        for (int unsigned k = 1; k <= 32; k++) begin
            m = rotl(m);
            sb.push_back('{c + 4 * k, m});
        end
        drain(200, "shl");
        n_tests++; if (led_din !== 32'h1) begin n_fail++; $display("FAIL shl_final_din: got %h, required 00000001", led_din); end
        bus_read(ADDR_STATUS, r);
        n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL shl_wrap: got %h, required 00000001", r); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL shl_irq_masked: got %b, required 0", irq); end
        bus_write(ADDR_CTRL, 32'h0, e);
        bus_write(ADDR_STATUS, 32'h0, e);
        bus_read(ADDR_STATUS, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL shl_wrap_clear: got %h, required 0", r); end
    endtask

    task automatic test_blink();
        int unsigned e, c;
        logic [31:0] r;
        bus_write(ADDR_PERIOD, 32'd3, e);
        bus_write(ADDR_DATA, 32'hF0, e);
        sb.push_back('{e, 32'hF0});
        bus_write(ADDR_CTRL, 32'h5, c);
        sb.push_back('{c + 3, 32'hFFFF_FF0F});
        sb.push_back('{c + 6, 32'h0000_00F0});
        drain(20, "blink");
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL blink_irq_set: got %b, required 1", irq); end
        bus_read(ADDR_STATUS, r);
        n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL blink_wrap: got %h, required 00000001", r); end
        sb.push_back('{c + 9, 32'hFFFF_FF0F});
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF, e);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL blink_irq_clear: got %b, required 0", irq); end
        drain(20, "blink_third");
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL blink_irq_stays_clear: got %b, required 0", irq); end
        bus_write(ADDR_CTRL, 32'h0, e);
    endtask

    task automatic test_back_to_back();
        int unsigned e, c;
        logic [31:0] m, r;
        bus_write(ADDR_PERIOD, 32'd5, e);
        bus_write(ADDR_DATA, 32'h1, e);
        sb.push_back('{e, 32'h1});
        bus_write(ADDR_CTRL, 32'h2, c);
        sb.push_back('{c + 5, 32'h2});
        sb.push_back('{c + 10, 32'h4});
        wait_until(c + 14);
        bus_write(ADDR_DATA, 32'h55, e);
        n_tests++; if (e !== c + 15) begin n_fail++; $display("FAIL collide_timing: write at cycle %0d, required %0d", e, c + 15); end
        sb.push_back('{e, 32'h55});
        m = 32'h55;
        for (int unsigned j = 1; j <= 29; j++) begin
            m = rotl(m);
            sb.push_back('{e + 5 * j, m});
        end
        drain(200, "collide");
        bus_read(ADDR_STATUS, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL collide_step_no_early_wrap: got %h, required 0", r); end
        m = rotl(m);
        sb.push_back('{e + 150, m});
        drain(20, "collide_wrap");
        bus_read(ADDR_STATUS, r);
        n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL collide_step_wrap: got %h, required 00000001", r); end
        bus_write(ADDR_CTRL, 32'h0, e);
        bus_write(ADDR_STATUS, 32'h0, e);
    endtask

    task automatic test_period_zero();
        int unsigned e, c, p;
        bus_write(ADDR_PERIOD, 32'd0, e);
        bus_write(ADDR_DATA, 32'h80, e);
        sb.push_back('{e, 32'h80});
        bus_write(ADDR_CTRL, 32'h3, c);
        idle(100);
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL period0_pending: %0d pulses pending, required 0", sb.size()); sb.delete(); end
        bus_write(ADDR_PERIOD, 32'd2, p);
        sb.push_back('{p + 2, rotr(32'h80)});
        sb.push_back('{p + 4, rotr(rotr(32'h80))});
        wait_until(p + 4);
        bus_write(ADDR_CTRL, 32'h0, e);
        drain(10, "period_resume");
    endtask

    task automatic test_pwm();
        int unsigned e, hi;
        logic [31:0] r;
`ifdef LED_SEQ_PWM_EN
        bus_write(ADDR_DUTY, 32'd64, e);
        bus_read(ADDR_DUTY, r);
        n_tests++; if (r !== 32'd64) begin n_fail++; $display("FAIL pwm_duty_readback: got %h, required 00000040", r); end
        hi = 0;
        repeat (256) begin @(posedge clk); #1; if (led_en === 1'b1) hi++; end
        n_tests++; if (hi !== 64) begin n_fail++; $display("FAIL pwm_duty64: high %0d of 256, required 64", hi); end
        bus_write(ADDR_DUTY, 32'hFF, e);
        hi = 0;
        repeat (256) begin @(posedge clk); #1; if (led_en === 1'b1) hi++; end
        n_tests++; if (hi !== 256) begin n_fail++; $display("FAIL pwm_duty_full: high %0d of 256, required 256", hi); end
        bus_write(ADDR_DUTY, 32'd64, e);
`else
        bus_write(ADDR_DUTY, 32'd64, e);
        bus_read(ADDR_DUTY, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL duty_ignored: got %h, required 0", r); end
        hi = 0;
        repeat (64) begin @(posedge clk); #1; if (led_en === 1'b1) hi++; end
        n_tests++; if (hi !== 64) begin n_fail++; $display("FAIL led_en_tied: high %0d of 64, required 64", hi); end
`endif
    endtask

    task automatic test_reset_mid();
        int unsigned e, c;
        logic [31:0] r;
        bus_write(ADDR_PERIOD, 32'd2, e);
        bus_write(ADDR_DATA, 32'h20, e);
        sb.push_back('{e, 32'h20});
        bus_write(ADDR_CTRL, 32'h5, c);
        sb.push_back('{c + 2, ~32'h20});
        sb.push_back('{c + 4, 32'h20});
        wait_until(c + 5);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL midreset_irq_before: got %b, required 1", irq); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (led_we !== 1'b0)   begin n_fail++; $display("FAIL midreset_led_we: got %b, required 0", led_we); end
        n_tests++; if (led_din !== 32'h0) begin n_fail++; $display("FAIL midreset_led_din: got %h, required 0", led_din); end
        n_tests++; if (irq !== 1'b0)      begin n_fail++; $display("FAIL midreset_irq: got %b, required 0", irq); end
        n_tests++; if (led_en !== 1'b1)   begin n_fail++; $display("FAIL midreset_led_en: got %b, required 1", led_en); end
        for (int a = 0; a < 5; a++) begin
            bus_read(3'(a), r);
            n_tests++;
            if (r !== ((a == 4) ? DUTY_RST : 32'h0)) begin
                n_fail++;
                $display("FAIL midreset_rdata[%0d]: got %h, required %h", a, r, (a == 4) ? DUTY_RST : 32'h0);
            end
        end
        reset = 1'b0;
        drain(5, "midreset");
        idle(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_manual();
        test_shl();
        test_blink();
        test_back_to_back();
        test_period_zero();
        test_pwm();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
